fc_layer_q: RTL and testbench

Parametrised fixed-point fully-connected layer, successor to the current fc_layer at the tail of the CNN pipeline. Consumes a flattened feature map, a row-major weight stream and a bias stream over one shared serial handshake. Emits OUT_SIZE saturated neuron outputs in order, plus the argmax class index. Adds generic width and fraction format, output saturation, optional ReLU, stall tolerance and on-chip argmax.

---
 rtl/fc_layer_q.sv | 188 ++++++++++++++++++
 tb/tb_fc_layer_q.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_q.sv
`default_nettype none
// fc_layer_q: serial fixed-point fully-connected layer with output saturation,
// optional ReLU and on-chip argmax.  Rev 1.0
module fc_layer_q #(
  parameter int IN_SIZE    = 75,
  parameter int OUT_SIZE   = 10,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int RELU       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_fc,
  input  logic                          data_valid,
  input  logic [DATA_WIDTH-1:0]         map_in_serial,
  input  logic [DATA_WIDTH-1:0]         weight_serial,
  input  logic [DATA_WIDTH-1:0]         bias_serial,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         predict_out,
  output logic                          predict_out_valid,
  output logic [$clog2(OUT_SIZE)-1:0]   predict_class,
  output logic                          finish_fc
);

  localparam int IW = $clog2(IN_SIZE);
  localparam int CW = $clog2(OUT_SIZE);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAP = 3'd1,
    S_MAC      = 3'd2,
    S_BIAS     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                        state_q;
  logic [IW-1:0]                 col_q;
  logic [CW-1:0]                 row_q;
  logic signed [DATA_WIDTH-1:0]  map_q [IN_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc_q [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0]  pipe_q;
  logic                          pipe_vld_q;
  logic [CW-1:0]                 pipe_idx_q;
  logic signed [DATA_WIDTH-1:0]  out_q;
  logic                          out_vld_q;
  logic signed [DATA_WIDTH-1:0]  max_q;
  logic [CW-1:0]                 arg_q;
  logic [CW-1:0]                 class_q;
  logic                          busy_q;
  logic                          finish_q;

  logic signed [2*DATA_WIDTH-1:0] prod_d;
  logic signed [ACC_WIDTH-1:0]    bias_ext_d;
  logic signed [ACC_WIDTH-1:0]    sum_d;
  logic signed [ACC_WIDTH-1:0]    shift_d;
  logic signed [DATA_WIDTH-1:0]   sat_d;
  logic                           last_col_d;
  logic                           last_row_d;

  always_comb begin
    prod_d     = map_q[col_q] * $signed(weight_serial);
    bias_ext_d = {{(ACC_WIDTH-DATA_WIDTH){bias_serial[DATA_WIDTH-1]}}, bias_serial};
    sum_d      = acc_q[row_q] + (bias_ext_d <<< FRAC_BITS);
    shift_d    = sum_d >>> FRAC_BITS;
    if (shift_d > SAT_MAX) begin
      sat_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shift_d < SAT_MIN) begin
      sat_d = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_d = shift_d[DATA_WIDTH-1:0];
    end
    if ((RELU != 0) && sat_d[DATA_WIDTH-1]) begin
      sat_d = '0;
    end
    last_col_d = (col_q == IW'(IN_SIZE - 1));
    last_row_d = (row_q == CW'(OUT_SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      for (int j = 0; j < OUT_SIZE; j++) acc_q[j] <= '0;
      pipe_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      max_q      <= OUT_MIN;
      arg_q      <= '0;
      class_q    <= '0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q   <= 1'b0;
      out_vld_q  <= pipe_vld_q;
      pipe_vld_q <= 1'b0;
      // Output stage doubles as the argmax update; strict > keeps the lowest index on ties.
      if (pipe_vld_q) begin
        out_q <= pipe_q;
        if (pipe_q > max_q) begin
          max_q <= pipe_q;
          arg_q <= pipe_idx_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_fc) begin
            state_q <= S_LOAD_MAP;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            for (int j = 0; j < OUT_SIZE; j++) acc_q[j] <= '0;
            max_q   <= OUT_MIN;
            arg_q   <= '0;
          end
        end
        S_LOAD_MAP: begin
          if (data_valid) begin
            map_q[col_q] <= map_in_serial;
            if (last_col_d) begin
              col_q   <= '0;
              state_q <= S_MAC;
            end else begin
              col_q <= col_q + IW'(1);
            end
          end
        end
        S_MAC: begin
          if (data_valid) begin
            acc_q[row_q] <= acc_q[row_q] + ACC_WIDTH'(prod_d);
            if (last_col_d) begin
              col_q <= '0;
              if (last_row_d) begin
                row_q   <= '0;
                state_q <= S_BIAS;
              end else begin
                row_q <= row_q + CW'(1);
              end
            end else begin
              col_q <= col_q + IW'(1);
            end
          end
        end
        S_BIAS: begin
          if (data_valid) begin
            pipe_q     <= sat_d;
            pipe_vld_q <= 1'b1;
            pipe_idx_q <= row_q;
            if (last_row_d) begin
              row_q   <= '0;
              state_q <= S_DONE;
            end else begin
              row_q <= row_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          // Wait for the last neuron to leave the output stage before reporting.
          if (!pipe_vld_q) begin
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            class_q  <= arg_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign predict_out       = out_q;
  assign predict_out_valid = out_vld_q;
  assign predict_class     = class_q;
  assign finish_fc         = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_q.sv
`default_nettype none
// tb_fc_layer_q: table-driven and randomized checks of fc_layer_q against an
// arithmetic reference model. Rev 1.0
module tb_fc_layer_q;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dv = 1'b0;
  logic [15:0] map_w = '0, wt_w = '0, bias_w = '0;
  logic        start_a = 1'b0, start_b = 1'b0, start_d = 1'b0;

  logic        busy_a, pv_a, fin_a, pc_a;
  logic [15:0] po_a;
  logic        busy_b, pv_b, fin_b;
  logic [1:0]  pc_b;
  logic [15:0] po_b;
  logic        busy_d, pv_d, fin_d;
  logic [3:0]  pc_d;
  logic [15:0] po_d;

  always #5 clk = ~clk;

  fc_layer_q #(.IN_SIZE(2), .OUT_SIZE(2), .RELU(0)) u_a (
    .clk(clk), .reset(reset), .start_fc(start_a), .data_valid(dv),
    .map_in_serial(map_w), .weight_serial(wt_w), .bias_serial(bias_w),
    .busy(busy_a), .predict_out(po_a), .predict_out_valid(pv_a),
    .predict_class(pc_a), .finish_fc(fin_a));

  fc_layer_q #(.IN_SIZE(2), .OUT_SIZE(3), .RELU(1)) u_b (
    .clk(clk), .reset(reset), .start_fc(start_b), .data_valid(dv),
    .map_in_serial(map_w), .weight_serial(wt_w), .bias_serial(bias_w),
    .busy(busy_b), .predict_out(po_b), .predict_out_valid(pv_b),
    .predict_class(pc_b), .finish_fc(fin_b));

  fc_layer_q u_d (
    .clk(clk), .reset(reset), .start_fc(start_d), .data_valid(dv),
    .map_in_serial(map_w), .weight_serial(wt_w), .bias_serial(bias_w),
    .busy(busy_d), .predict_out(po_d), .predict_out_valid(pv_d),
    .predict_class(pc_d), .finish_fc(fin_d));

  logic [15:0] outs_a[$], outs_b[$], outs_d[$];

  always @(negedge clk) begin
    if (pv_a) outs_a.push_back(po_a);
    if (pv_b) outs_b.push_back(po_b);
    if (pv_d) outs_d.push_back(po_d);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  logic signed [15:0] s_map[], s_wt[], s_bs[];

  function automatic logic fin_of(input int inst);
    case (inst)
      0: return fin_a;
      1: return fin_b;
      default: return fin_d;
    endcase
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return busy_a;
      1: return busy_b;
      default: return busy_d;
    endcase
  endfunction

  function automatic int class_of(input int inst);
    case (inst)
      0: return int'(pc_a);
      1: return int'(pc_b);
      default: return int'(pc_d);
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_a = v;
      1: start_b = v;
      default: start_d = v;
    endcase
  endtask

  task automatic junk();
    map_w  = 16'($urandom);
    wt_w   = 16'($urandom);
    bias_w = 16'($urandom);
  endtask

  // Streams map, weights and biases; optionally stalls every other cycle,
  // pulses start during MAC, or asserts reset on a given weight word.
  task automatic run_pass(input int inst, input int nin, input int nout,
                          input bit stall, input bit pulse, input int rst_at);
    int total;
    total = nin + nin * nout + nout;
    case (inst)
      0: outs_a = {};
      1: outs_b = {};
      default: outs_d = {};
    endcase
    @(negedge clk); set_start(inst, 1'b1);
    @(negedge clk); set_start(inst, 1'b0);
    for (int k = 0; k < total; k++) begin
      if (stall) begin
        dv = 1'b0; junk();
        @(negedge clk);
      end
      junk(); dv = 1'b1;
      if (k < nin) begin
        map_w = s_map[k];
      end else if (k < nin + nin * nout) begin
        wt_w = s_wt[k - nin];
        if (pulse && k == nin + 1) set_start(inst, 1'b1);
        if (k - nin == rst_at) reset = 1'b1;
      end else begin
        bias_w = s_bs[k - nin - nin * nout];
      end
      @(negedge clk);
      set_start(inst, 1'b0);
      if (reset) begin
        reset = 1'b0; dv = 1'b0;
        return;
      end
    end
    dv = 1'b0; junk();
  endtask

  task automatic model(input int nin, input int nout, input bit relu,
                       output logic [15:0] exp[$], output int cls);
    longint acc, s;
    exp = {};
    for (int j = 0; j < nout; j++) begin
      acc = 0;
      for (int i = 0; i < nin; i++) acc += longint'(s_map[i]) * longint'(s_wt[j * nin + i]);
      s = (acc + longint'(s_bs[j]) * 256) >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      exp.push_back(s[15:0]);
    end
    cls = 0;
    for (int j = 1; j < nout; j++)
      if ($signed(exp[j]) > $signed(exp[cls])) cls = j;
  endtask

  task automatic finish_and_compare(input string tag, input int inst, input int nout,
                                    input logic [15:0] exp[$], input int cls);
    int lat;
    logic [15:0] got[$];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!fin_of(inst) && lat < 40);
    check({tag, "_finish_latency"}, lat, 2);
    check({tag, "_busy_at_finish"}, busy_of(inst), 1'b0);
    repeat (2) @(negedge clk);
    case (inst)
      0: got = outs_a;
      1: got = outs_b;
      default: got = outs_d;
    endcase
    check({tag, "_strobe_count"}, got.size(), nout);
    for (int j = 0; j < nout; j++)
      check($sformatf("%s_out%0d", tag, j), (j < got.size()) ? got[j] : 16'hxxxx, exp[j]);
    check({tag, "_class"}, class_of(inst), cls);
  endtask

  typedef struct {
    string       name;
    int          inst;
    int          nout;
    bit          stall;
    bit          pulse;
    logic [15:0] mp[2];
    logic [15:0] wt[6];
    logic [15:0] bs[3];
    logic [15:0] ex[3];
    int          cls;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [15:0] exp[$];
    int cls;

    tbl[0] = '{"basic", 0, 2, 0, 0, '{16'h0100, 16'h0200},
               '{16'h0100, 16'h0100, 16'hFF00, 16'h0080, 16'h0000, 16'h0000},
               '{16'h0080, 16'h0000, 16'h0000}, '{16'h0380, 16'h0000, 16'h0000}, 0};
    tbl[1] = '{"sat_pos", 0, 2, 0, 0, '{16'h7FFF, 16'h7FFF},
               '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000},
               '{16'h7FFF, 16'h7FFF, 16'h0000}, '{16'h7FFF, 16'h7FFF, 16'h0000}, 0};
    tbl[2] = '{"sat_neg", 0, 2, 0, 0, '{16'h7FFF, 16'h7FFF},
               '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h0000, 16'h0000},
               '{16'h7FFF, 16'h7FFF, 16'h0000}, '{16'h8000, 16'h8000, 16'h0000}, 0};
    tbl[3] = '{"floor", 0, 2, 0, 0, '{16'h0001, 16'h0000},
               '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000},
               '{16'h0000, 16'h0000, 16'h0000}, '{16'hFFFF, 16'h0000, 16'h0000}, 1};
    tbl[4] = '{"relu", 1, 3, 0, 0, '{16'h0100, 16'h0200},
               '{16'h0100, 16'h0100, 16'hFF00, 16'h0080, 16'h0000, 16'h0000},
               '{16'h0080, 16'hFF00, 16'h0000}, '{16'h0380, 16'h0000, 16'h0000}, 0};
    tbl[5] = '{"ties", 1, 3, 0, 0, '{16'h0100, 16'h0100},
               '{16'h0100, 16'h0100, 16'h0200, 16'h0000, 16'h0080, 16'h0080},
               '{16'h0000, 16'h0000, 16'h0000}, '{16'h0200, 16'h0200, 16'h0100}, 0};
    tbl[6] = '{"argmax", 1, 3, 0, 0, '{16'h0100, 16'h0100},
               '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000},
               '{16'h0000, 16'h0000, 16'h0000}, '{16'h0000, 16'h0000, 16'h0100}, 2};
    tbl[7] = tbl[0]; tbl[7].name = "stall"; tbl[7].stall = 1'b1;
    tbl[8] = tbl[5]; tbl[8].name = "start_pulse"; tbl[8].pulse = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {busy_a, busy_b, busy_d}, 3'b000);
    check("reset_out", {po_a, po_b, po_d}, 48'h0);
    check("reset_valid", {pv_a, pv_b, pv_d}, 3'b000);
    check("reset_class", {pc_a, pc_b, pc_d}, 7'h0);
    check("reset_finish", {fin_a, fin_b, fin_d}, 3'b000);

    for (int t = 0; t < 9; t++) begin
      s_map = new[2]; s_wt = new[2 * tbl[t].nout]; s_bs = new[tbl[t].nout];
      for (int i = 0; i < 2; i++) s_map[i] = tbl[t].mp[i];
      for (int i = 0; i < 2 * tbl[t].nout; i++) s_wt[i] = tbl[t].wt[i];
      for (int i = 0; i < tbl[t].nout; i++) s_bs[i] = tbl[t].bs[i];
      exp = {};
      for (int i = 0; i < tbl[t].nout; i++) exp.push_back(tbl[t].ex[i]);
      run_pass(tbl[t].inst, 2, tbl[t].nout, tbl[t].stall, tbl[t].pulse, -1);
      finish_and_compare(tbl[t].name, tbl[t].inst, tbl[t].nout, exp, tbl[t].cls);
    end

    // Full-size randomized passes, with a mid-MAC reset between them.
    for (int p = 0; p < 3; p++) begin
      s_map = new[75]; s_wt = new[750]; s_bs = new[10];
      foreach (s_map[i]) s_map[i] = 16'($signed($urandom_range(0, 1023)) - 512);
      foreach (s_wt[i])  s_wt[i]  = 16'($signed($urandom_range(0, 1023)) - 512);
      foreach (s_bs[i])  s_bs[i]  = 16'($urandom);
      if (p == 1) begin
        run_pass(2, 75, 10, 1'b0, 1'b0, 30);
        check("midreset_busy", busy_d, 1'b0);
        check("midreset_out", po_d, 16'h0);
        check("midreset_valid", pv_d, 1'b0);
        check("midreset_class", pc_d, 4'h0);
        repeat (3) @(negedge clk);
        check("midreset_no_strobe", outs_d.size(), 0);
      end else begin
        model(75, 10, 1'b0, exp, cls);
        run_pass(2, 75, 10, p == 2, 1'b0, -1);
        finish_and_compare($sformatf("rand%0d", p), 2, 10, exp, cls);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
